// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into HOLD/GAP windows on a registered `out` level.
// Optional macro PULSE_QUEUE_EN: queue events arriving mid-window in a saturating counter.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             dropped
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_gap;
  logic          enq;
  logic          drop_nxt;

  // The last GAP cycle is where queued work (or a fresh pulse) restarts HOLD.
  assign last_gap = (state == GAP) && (timer == '0);
  // A pulse mid-window that is not consumed directly by the last-GAP restart.
  assign enq      = pulse && ((state == HOLD) || ((state == GAP) && (timer != '0)));

`ifdef PULSE_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_nxt;
  logic             deq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == PEND_MAX) ? v : v + 1'b1;
  endfunction

  assign deq = last_gap && (pend_q != '0);

  always_comb begin
    pend_nxt = pend_q;
    drop_nxt = 1'b0;
    if (deq) begin
      // A coincident pulse replaces the replayed event, so the count holds.
      pend_nxt = pulse ? pend_q : pend_q - 1'b1;
    end else if (enq) begin
      if (pend_q == PEND_MAX) drop_nxt = 1'b1;
      else                    pend_nxt = sat_inc(pend_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_nxt;
  end

  assign pending = pend_q;
`else
  assign drop_nxt = enq;
  assign pending  = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_nxt;
      case (state)
        IDLE: begin
          if (pulse) begin
            state <= HOLD;
            timer <= HOLD_LOAD;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state <= GAP;
            timer <= GAP_LOAD;
            out   <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (last_gap) begin
`ifdef PULSE_QUEUE_EN
            if (pend_q != '0 || pulse) begin
`else
            if (pulse) begin
`endif
              state <= HOLD;
              timer <= HOLD_LOAD;
              out   <= 1'b1;
            end else begin
              state <= IDLE;
              timer <= '0;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: number of cycles `out` is held high per event; minimum 1.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: number of forced low cycles after each hold; minimum 1.
REQ-003 SHALL have parameter CNT_W, default 4: width of the pending-event counter.
REQ-004 Port `clock`  in  1: clock; all state updates on posedge.
REQ-005 Port `reset`  in  1: reset, synchronous, active-high; clock `clock`.
REQ-006 Port `pulse`  in  1: one-cycle event strobe, already synchronous to `clock`.
REQ-007 Port `out`  out  1: stretched, human-visible level (LED or buzzer drive).
REQ-008 Port `busy`  out  1: high whenever the state is not IDLE.
REQ-009 Port `pending`  out  CNT_W: count of queued events not yet replayed.
REQ-010 Port `dropped`  out  1: one-cycle strobe, high in the cycle after an event is lost.

Function
REQ-011 FSM SHALL have three states: IDLE, HOLD, GAP. `out` SHALL be high exactly when the state is HOLD, and SHALL be driven from a register.
REQ-012 In IDLE, a `pulse` in cycle t SHALL set the state to HOLD, so `out` is high in cycles t+1 through t+HOLD_CYCLES.
REQ-013 After HOLD_CYCLES cycles in HOLD, the state SHALL go to GAP for exactly GAP_CYCLES cycles.
REQ-014 On the last GAP cycle, the next state SHALL be:
- HOLD if `pending` > 0, with `pending` decremented by 1;
- HOLD if `pending` == 0 and `pulse` is high, consuming that pulse directly;
- IDLE otherwise.
REQ-015 A `pulse` during HOLD or GAP, other than the case consumed in REQ-014, SHALL be handled per REQ-023/REQ-024.
REQ-016 A `pulse` that coincides with a `pending` decrement SHALL leave `pending` unchanged and SHALL NOT be dropped, even when `pending` is at its maximum.
REQ-017 `pending` SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-018 The hold/gap counter SHALL be wide enough for max(HOLD_CYCLES, GAP_CYCLES) and SHALL be reloaded on every state entry.
REQ-019 `dropped` SHALL be registered and high for exactly one cycle per lost event.

Reset
REQ-020 While `reset` is high, the block SHALL set: state = IDLE, `out` = 0, `busy` = 0, `pending` = 0, `dropped` = 0, counter = 0.
REQ-021 A `pulse` in a cycle where `reset` is high SHALL be ignored.
REQ-022 Reset asserted mid-HOLD or mid-GAP SHALL abort immediately; queued events SHALL be discarded and SHALL NOT be reported as dropped.

Configuration
REQ-023 With macro PULSE_QUEUE_EN defined:
- a `pulse` during HOLD or GAP SHALL increment `pending`;
- if `pending` is already at maximum, the pulse SHALL be lost and `dropped` SHALL assert.
REQ-024 Without PULSE_QUEUE_EN:
- `pending` SHALL be constant 0 and no counter logic SHALL be instantiated;
- every `pulse` during HOLD or GAP, other than the case consumed in REQ-014, SHALL be lost and SHALL assert `dropped`.

Verification
All scenarios use default parameters unless stated.
REQ-025 Reset, then `pulse` at cycle 10 -> `out` high in cycles 11-18, `busy` high in cycles 11-22, IDLE at 23, `dropped` never asserted.
REQ-026 PULSE_QUEUE_EN defined, `pulse` at cycles 10, 11, 12:
- `pending` = 2 at cycle 13;
- `out` high in cycles 11-18, 23-30 and 35-42;
- `pending` = 1 at 23 and 0 at 35.
REQ-027 PULSE_QUEUE_EN defined, HOLD_CYCLES=32, `pulse` every cycle from 10 to 26 -> `pending` saturates at 15, `dropped` high in cycle 27 only.
REQ-028 PULSE_QUEUE_EN undefined, `pulse` at cycles 10 and 14 -> one hold window only (cycles 11-18), `dropped` high in cycle 15, `pending` stays 0.
REQ-029 `pulse` at 10, second `pulse` at 22 (the last GAP cycle) with `pending` 0 -> `out` high in cycles 11-18, then again in 23-30 with no IDLE cycle in between.
REQ-030 PULSE_QUEUE_EN defined, queued events present, `reset` at cycle 15 together with a `pulse` -> at cycle 16 `out` = 0, `pending` = 0, `busy` = 0, and `dropped` not asserted.
